slice_size_table_ctrl: RTL and testbench
========================================

// Module: slice_size_table_ctrl
// PURPOSE
//   Collects per-slice coded byte sizes from the slice encoders, then serialises them into the
//   bitstream packer as the picture's slice size table. Emits one 16-bit entry per slice, in
//   slice-index order, using the packer's {output_enable, val, size_of_bit, flush_bit} format.
//   Sits between the slice encoder array and the bit-writer mux, ahead of the slice data.
// PARAMETERS
//   ADDR_W        8   index width; MAX_SLICES = 2**ADDR_W table entries
//   SIZE_W        16  bits per emitted table entry (ProRes slice size field)
//   FLUSH_AT_END  0   1: emit one flush beat after the last entry
// PORTS
//   clock          in   1       rising-edge clock
//   reset_n        in   1       asynchronous, active-low reset
//   start          in   1       1-cycle pulse; begins a picture (honoured only in IDLE)
//   slice_num      in   32      slices in this picture; sampled on accepted start
//   size_valid     in   1       size_idx/size_bytes valid this cycle
//   size_idx       in   ADDR_W  slice index of reported size
//   size_bytes     in   32      coded size of that slice, in bytes
//   out_ready      in   1       packer can accept a beat this cycle
//   output_enable  out  1       beat valid (registered)
//   val            out  64      {zeros, entry}; entry is in bits [SIZE_W-1:0]
//   size_of_bit    out  64      beat width in bits: SIZE_W for entries, 0 for the flush beat
//   flush_bit      out  1       high only on the flush beat
//   busy           out  1       state != IDLE
//   done           out  1       1-cycle pulse when the table is fully emitted
//   sat_err        out  1       sticky: some size_bytes > 2**SIZE_W-1; cleared on accepted start
//   cfg_err        out  1       sticky: bad slice_num or bad size_idx; cleared on accepted start
// BEHAVIOUR
//   Reset: state = IDLE; all outputs 0; counters, sampled slice_num and per-entry valid bits cleared.
//     Asserting reset mid-picture abandons the picture. No done pulse is produced.
//   FSM states: IDLE -> COLLECT -> EMIT -> (FLUSH) -> DONE -> IDLE.
//   IDLE: start=1 latches N = slice_num, clears the valid bits, collected count, sat_err and cfg_err.
//     If N == 0 or N > MAX_SLICES: set cfg_err and go to DONE; nothing is emitted.
//     Otherwise go to COLLECT. size_valid is ignored in IDLE.
//   COLLECT: on size_valid with size_idx < N:
//     - write table[size_idx] = min(size_bytes, 2**SIZE_W-1); set sat_err if the value was clamped.
//     - increment the collected count only if the entry was not already valid.
//     - a duplicate index overwrites the entry and does not increment the count.
//     size_idx >= N: the write is dropped and cfg_err is set.
//     When collected reaches N (including via this cycle's write), the next state is EMIT.
//   EMIT: read pointer rd starts at 0.
//     Each cycle with out_ready=1: the next cycle drives output_enable=1, val={0, table[rd]},
//       size_of_bit=SIZE_W, flush_bit=0, and rd increments.
//     A cycle with out_ready=0 yields output_enable=0, val=0, size_of_bit=0 the next cycle.
//     Latency: 1 cycle from the ready cycle to the beat.
//     After entry N-1 is issued: go to FLUSH if FLUSH_AT_END, else DONE.
//   FLUSH: waits for out_ready. The next cycle drives output_enable=1, val=0, size_of_bit=0,
//     flush_bit=1. Then go to DONE.
//   DONE: done=1 for exactly one cycle. Outputs otherwise idle. Next state is IDLE.
//   start while busy is ignored. size_valid outside COLLECT is ignored.
//   Exactly N beats (+1 flush) are produced per picture. Beats are never duplicated or skipped.
//   Width rules:
//     - internal count and rd are ADDR_W+1 bits, so N = MAX_SLICES does not wrap.
//     - val[63:SIZE_W] is always 0.
// TESTING
//   1 N=4; sizes 100,200,300,400 in order; out_ready=1 -> 4 beats val=100..400, size_of_bit=16; done 1 cycle after the last beat.
//   2 N=3; idx order 2,0,1; out_ready toggling 1,0,1,0 -> beats stay in idx order 0,1,2; output_enable low after every ready=0 cycle.
//   3 N=2; idx0=70000, idx1=5 -> beats 0xFFFF then 5; sat_err=1 until next start.
//   4 N=2; idx0 sent twice (10 then 20), idx5, then idx1=30 -> no EMIT before idx1; beats 20,30; cfg_err=1.
//   5 N=0, then N=300 (ADDR_W=8) -> done pulse, cfg_err=1, zero beats; N=256 -> 256 beats, no wrap.
//   6 FLUSH_AT_END=1, N=1 -> entry beat, then flush beat (flush_bit=1, size_of_bit=0); reset mid-EMIT -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/slice_size_table_ctrl_if.sv
// Packer-side beat bus of the slice size table controller.
// Handshake: out_ready is sampled on a rising edge. If it is high while an entry
// or flush is pending, the beat is presented on the following cycle with
// output_enable=1. output_enable is never held waiting for ready, and a cycle
// without ready always yields an all-zero, disabled beat on the next cycle.
interface slice_size_table_ctrl_if;
  logic        output_enable;
  logic [63:0] val;
  logic [63:0] size_of_bit;
  logic        flush_bit;
  logic        out_ready;

  modport master (
    output output_enable,
    output val,
    output size_of_bit,
    output flush_bit,
    input  out_ready
  );

  modport slave (
    input  output_enable,
    input  val,
    input  size_of_bit,
    input  flush_bit,
    output out_ready
  );
endinterface

// File: rtl/slice_size_table_ctrl.sv
// Slice size table controller: gathers per-slice coded sizes in any order,
// then streams them to the bitstream packer in slice-index order.
module slice_size_table_ctrl #(
  parameter int ADDR_W       = 8,
  parameter int SIZE_W       = 16,
  parameter int FLUSH_AT_END = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           slice_num,
  input  logic                  size_valid,
  input  logic [ADDR_W-1:0]     size_idx,
  input  logic [31:0]           size_bytes,
  slice_size_table_ctrl_if.master packer,
  output logic                  busy,
  output logic                  done,
  output logic                  sat_err,
  output logic                  cfg_err,
  output logic [2:0]            state_dbg
);

  localparam int          MAX_SLICES = 2 ** ADDR_W;
  localparam logic [31:0] MAX_N      = 32'(MAX_SLICES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_EMIT    = 3'd2,
    S_FLUSH   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                 state;
  // Counters are one bit wider than the index so a full table does not wrap.
  logic [ADDR_W:0]        n_q;
  logic [ADDR_W:0]        cnt;
  logic [ADDR_W:0]        rd;
  logic [MAX_SLICES-1:0]  valid_q;
  logic [SIZE_W-1:0]      table_q [MAX_SLICES];

  logic                   start_bad;
  logic                   idx_ok;
  logic                   sat_hi;
  logic [SIZE_W-1:0]      clamped;
  logic                   write_en;
  logic [ADDR_W:0]        cnt_next;
  logic                   rd_last;

  assign start_bad = (slice_num == 32'd0) || (slice_num > MAX_N);
  assign idx_ok    = ({1'b0, size_idx} < n_q);
  assign sat_hi    = |size_bytes[31:SIZE_W];
  assign clamped   = sat_hi ? {SIZE_W{1'b1}} : size_bytes[SIZE_W-1:0];
  assign write_en  = (state == S_COLLECT) && size_valid && idx_ok;
  assign cnt_next  = cnt + {{ADDR_W{1'b0}}, (write_en && !valid_q[size_idx])};
  assign rd_last   = (rd == (n_q - (ADDR_W+1)'(1)));

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Table storage; contents are only meaningful where valid_q is set.
  always_ff @(posedge clock) begin
    if (write_en) table_q[size_idx] <= clamped;
  end

  // Control FSM with registered beat outputs and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state                <= S_IDLE;
      n_q                  <= '0;
      cnt                  <= '0;
      rd                   <= '0;
      valid_q              <= '0;
      sat_err              <= 1'b0;
      cfg_err              <= 1'b0;
      done                 <= 1'b0;
      packer.output_enable <= 1'b0;
      packer.val           <= '0;
      packer.size_of_bit   <= '0;
      packer.flush_bit     <= 1'b0;
    end else begin
      packer.output_enable <= 1'b0;
      packer.val           <= '0;
      packer.size_of_bit   <= '0;
      packer.flush_bit     <= 1'b0;
      done                 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            n_q     <= start_bad ? '0 : slice_num[ADDR_W:0];
            cnt     <= '0;
            rd      <= '0;
            valid_q <= '0;
            sat_err <= 1'b0;
            cfg_err <= start_bad;
            state   <= start_bad ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (size_valid) begin
            if (idx_ok) begin
              valid_q[size_idx] <= 1'b1;
              cnt               <= cnt_next;
              if (sat_hi) sat_err <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
            end
          end
          if (cnt_next == n_q) state <= S_EMIT;
        end
        S_EMIT: begin
          if (packer.out_ready) begin
            packer.output_enable <= 1'b1;
            packer.val           <= {{(64-SIZE_W){1'b0}}, table_q[rd[ADDR_W-1:0]]};
            packer.size_of_bit   <= 64'(SIZE_W);
            rd                   <= rd + (ADDR_W+1)'(1);
            if (rd_last) state <= (FLUSH_AT_END != 0) ? S_FLUSH : S_DONE;
          end
        end
        S_FLUSH: begin
          if (packer.out_ready) begin
            packer.output_enable <= 1'b1;
            packer.flush_bit     <= 1'b1;
            state                <= S_DONE;
          end
        end
        S_DONE: begin
          // The pulse lands on the cycle after the last beat.
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_size_table_ctrl.sv
// Bench for slice_size_table_ctrl: two instances (without and with end flush)
// share all stimulus; each has its own expected-beat queue and monitor checks.
module tb_slice_size_table_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] slice_num;
  logic        size_valid;
  logic [7:0]  size_idx;
  logic [31:0] size_bytes;
  logic        busy0, done0, sat0, cfg0;
  logic        busy1, done1, sat1, cfg1;
  logic [2:0]  st0, st1;

  slice_size_table_ctrl_if bus0();
  slice_size_table_ctrl_if bus1();

  // Clock/reset block
  always #5 clock = ~clock;

  slice_size_table_ctrl #(.ADDR_W(8), .SIZE_W(16), .FLUSH_AT_END(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start), .slice_num(slice_num),
    .size_valid(size_valid), .size_idx(size_idx), .size_bytes(size_bytes),
    .packer(bus0.master), .busy(busy0), .done(done0), .sat_err(sat0),
    .cfg_err(cfg0), .state_dbg(st0)
  );

  slice_size_table_ctrl #(.ADDR_W(8), .SIZE_W(16), .FLUSH_AT_END(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start), .slice_num(slice_num),
    .size_valid(size_valid), .size_idx(size_idx), .size_bytes(size_bytes),
    .packer(bus1.master), .busy(busy1), .done(done1), .sat_err(sat1),
    .cfg_err(cfg1), .state_dbg(st1)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: {last, flush_bit, size_of_bit, val}
  logic [129:0] exp_q0[$];
  logic [129:0] exp_q1[$];

  // Reference model: a picture as a plain array of slice sizes.
  int  m_n;
  bit  m_val[256];
  int  m_tab[256];
  int  m_cnt;
  bit  m_sat, m_cfg, m_col;
  int  pics;

  // Ready generator: 0 always, 1 random, 2 toggle, 3 held low
  int rdy_mode = 0;
  always @(negedge clock) begin
    logic r;
    case (rdy_mode)
      0: r = 1'b1;
      1: r = 1'($urandom_range(0, 1));
      2: r = ~bus0.out_ready;
      default: r = 1'b0;
    endcase
    bus0.out_ready = r;
    bus1.out_ready = r;
  end

  // Monitor
  bit rdy_cap;
  bit dn_next[2];
  int done_cnt[2];

  always @(posedge clock) rdy_cap = bus0.out_ready;

  task automatic mon_one(input int d, input logic oe, input logic [63:0] v,
                         input logic [63:0] sb, input logic fb, input logic dn);
    logic [129:0] e;
    bit have;
    if (dn_next[d]) chk($sformatf("done_after_last%0d", d), 129'(dn), 129'(1));
    dn_next[d] = 1'b0;
    if (dn) done_cnt[d]++;
    if (!rdy_cap) chk($sformatf("oe_low_after_not_ready%0d", d), 129'(oe), 129'(0));
    if (oe) begin
      have = 1'b0;
      if (d == 0 && exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
      if (d == 1 && exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat%0d actual=%0h required=none", d, {fb, sb, v});
      end else begin
        chk($sformatf("beat%0d", d), {fb, sb, v}, e[128:0]);
        dn_next[d] = e[129];
      end
    end else begin
      chk($sformatf("idle_bus%0d", d), {fb, sb, v}, 129'(0));
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      mon_one(0, bus0.output_enable, bus0.val, bus0.size_of_bit, bus0.flush_bit, done0);
      mon_one(1, bus1.output_enable, bus1.val, bus1.size_of_bit, bus1.flush_bit, done1);
    end
  end

  // Driver tasks
  task automatic push_beats();
    for (int i = 0; i < m_n; i++) begin
      exp_q0.push_back({(i == m_n - 1), 1'b0, 64'd16, 64'(m_tab[i])});
      exp_q1.push_back({1'b0, 1'b0, 64'd16, 64'(m_tab[i])});
    end
    exp_q1.push_back({1'b1, 1'b1, 64'd0, 64'd0});
  endtask

  task automatic start_pic(input int n);
    @(negedge clock);
    start = 1'b1;
    slice_num = n;
    @(negedge clock);
    start = 1'b0;
    pics++;
    m_sat = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 256; i++) m_val[i] = 1'b0;
    m_cfg = (n == 0 || n > 256);
    m_col = !m_cfg;
    m_n = n;
  endtask

  task automatic send_size(input int idx, input int bytes);
    @(negedge clock);
    size_valid = 1'b1;
    size_idx = 8'(idx);
    size_bytes = bytes;
    @(negedge clock);
    size_valid = 1'b0;
    if (m_col) begin
      if (idx < m_n) begin
        m_tab[idx] = (bytes > 65535) ? 65535 : bytes;
        if (bytes > 65535) m_sat = 1'b1;
        if (!m_val[idx]) m_cnt++;
        m_val[idx] = 1'b1;
        if (m_cnt == m_n) begin
          m_col = 1'b0;
          push_beats();
        end
      end else begin
        m_cfg = 1'b1;
      end
    end
  endtask

  task automatic finish_pic(input int budget);
    int k = 0;
    while ((busy0 || busy1) && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=busy required=idle");
    end
    repeat (3) @(negedge clock);
    chk("queue_drained0", 129'(exp_q0.size()), 129'(0));
    chk("queue_drained1", 129'(exp_q1.size()), 129'(0));
    chk("done_count0", 129'(done_cnt[0]), 129'(pics));
    chk("done_count1", 129'(done_cnt[1]), 129'(pics));
    chk("sat_err", {sat1, sat0}, {m_sat, m_sat});
    chk("cfg_err", {cfg1, cfg0}, {m_cfg, m_cfg});
  endtask

  function automatic int rnd_bytes();
    if ($urandom_range(0, 4) == 0) return int'($urandom_range(65536, 200000));
    return int'($urandom_range(0, 65535));
  endfunction

  task automatic random_pic(input int n);
    int perm[256];
    for (int i = 0; i < n; i++) perm[i] = i;
    for (int i = n - 1; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(0, i));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    start_pic(n);
    for (int k = 0; k < n; k++) begin
      if (k > 0 && $urandom_range(0, 3) == 0)
        send_size(perm[int'($urandom_range(0, k - 1))], rnd_bytes());
      if (n < 256 && $urandom_range(0, 5) == 0)
        send_size(int'($urandom_range(n, 255)), rnd_bytes());
      send_size(perm[k], rnd_bytes());
    end
    finish_pic(4000);
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {bus1.output_enable, bus1.flush_bit, bus1.val, bus1.size_of_bit[15:0],
               busy1, done1, sat1, cfg1, busy0, done0, sat0, cfg0,
               bus0.output_enable, bus0.flush_bit, bus0.size_of_bit[15:0], bus0.val[15:0]},
        129'(0));
  endtask

  task automatic clear_tracking();
    exp_q0.delete();
    exp_q1.delete();
    dn_next[0] = 1'b0; dn_next[1] = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    pics = 0;
    m_col = 1'b0; m_sat = 1'b0; m_cfg = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    slice_num = '0;
    size_valid = 1'b0;
    size_idx = '0;
    size_bytes = '0;
    clear_tracking();
    repeat (3) @(negedge clock);
    check_all_zero("reset_state");
    reset_n = 1'b1;

    // In-order picture, ready always high
    rdy_mode = 0;
    start_pic(4);
    send_size(0, 100); send_size(1, 200); send_size(2, 300); send_size(3, 400);
    finish_pic(200);

    // Out-of-order arrival, toggling ready
    rdy_mode = 2;
    start_pic(3);
    send_size(2, 33); send_size(0, 11); send_size(1, 22);
    finish_pic(200);

    // Saturation, including the exact clamp boundary
    rdy_mode = 0;
    start_pic(2);
    send_size(0, 70000); send_size(1, 5);
    finish_pic(200);
    start_pic(2);
    send_size(0, 65535); send_size(1, 65536);
    finish_pic(200);
    start_pic(2);
    send_size(0, 65535); send_size(1, 0);
    finish_pic(200);

    // Duplicate index and out-of-range index
    start_pic(2);
    send_size(0, 10); send_size(0, 20); send_size(5, 99);
    chk("no_beats_before_complete", 129'(done_cnt[0]), 129'(pics - 1));
    send_size(1, 30);
    finish_pic(200);

    // Bad picture sizes, then a full table
    start_pic(0);   finish_pic(50);
    start_pic(300); finish_pic(50);
    start_pic(257); finish_pic(50);
    random_pic(256);

    // Randomised pictures with random ready
    rdy_mode = 1;
    for (int p = 0; p < 15; p++) random_pic(int'($urandom_range(1, 24)));
    rdy_mode = 0;
    random_pic(1);

    // Reset in the middle of emission
    rdy_mode = 3;
    start_pic(4);
    send_size(0, 1); send_size(1, 2); send_size(2, 70000); send_size(3, 4);
    repeat (3) @(negedge clock);
    rdy_mode = 0;
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check_all_zero("reset_mid_emit");
    clear_tracking();
    @(negedge clock);
    reset_n = 1'b1;
    random_pic(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
